// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT butterfly sequencer.
// Drives the twiddle ROM and streams butterfly descriptors.
module fft_twiddle_sequencer #(
  parameter int MAX_N       = 32,
  parameter int ADDR_WIDTH  = $clog2(MAX_N),
  parameter int STAGE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    n_points,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_WIDTH-1:0]  rom_k,
  output logic [ADDR_WIDTH:0]    rom_n,
  input  logic [15:0]            rom_twiddle,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr_a,
  output logic [ADDR_WIDTH-1:0]  out_addr_b,
  output logic [15:0]            out_twiddle,
  output logic [STAGE_WIDTH-1:0] out_stage,
  output logic                   out_last_in_stage,
  output logic                   out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH:0]    n_reg;
  logic [STAGE_WIDTH-1:0] l_reg;
  logic [STAGE_WIDTH-1:0] s_cnt;
  logic [ADDR_WIDTH-1:0]  b_cnt;

  logic                   legal;
  logic [STAGE_WIDTH-1:0] l_dec;
  logic [ADDR_WIDTH-1:0]  half;
  logic [ADDR_WIDTH-1:0]  pos;
  logic [ADDR_WIDTH-1:0]  group;
  logic [ADDR_WIDTH-1:0]  addr_a;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [ADDR_WIDTH-1:0]  k;
  logic [ADDR_WIDTH-1:0]  b_max;
  logic                   stage_end;
  logic                   frame_end;
  logic                   load;
  logic                   xfer;

  // Decode n_points into legality and log2.
  always_comb begin
    legal = 1'b1;
    l_dec = '0;
    case (n_points)
      (ADDR_WIDTH+1)'(2):  l_dec = STAGE_WIDTH'(1);
      (ADDR_WIDTH+1)'(4):  l_dec = STAGE_WIDTH'(2);
      (ADDR_WIDTH+1)'(8):  l_dec = STAGE_WIDTH'(3);
      (ADDR_WIDTH+1)'(16): l_dec = STAGE_WIDTH'(4);
      (ADDR_WIDTH+1)'(32): l_dec = STAGE_WIDTH'(5);
      default:             legal = 1'b0;
    endcase
  end

  // Butterfly address and twiddle index from counters.
  always_comb begin
    half      = ADDR_WIDTH'(1) << s_cnt;
    pos       = b_cnt & (half - 1'b1);
    group     = b_cnt >> s_cnt;
    addr_a    = (group << (s_cnt + 1'b1)) | pos;
    addr_b    = addr_a + half;
    k         = pos << (l_reg - 1'b1 - s_cnt);
    b_max     = n_reg[ADDR_WIDTH:1] - 1'b1;
    stage_end = (b_cnt == b_max);
    frame_end = stage_end && (s_cnt == l_reg - 1'b1);
    load      = (state == RUN) && (!out_valid || out_ready);
    xfer      = out_valid && out_ready;
    busy      = (state != IDLE);
    rom_k     = (state == RUN) ? k : '0;
    rom_n     = (state == RUN) ? n_reg : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && legal) state_nx = RUN;
      RUN:     if (load && frame_end) state_nx = FLUSH;
      FLUSH:   if (xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame counters, descriptor register and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg             <= '0;
      l_reg             <= '0;
      s_cnt             <= '0;
      b_cnt             <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
      out_valid         <= 1'b0;
      out_addr_a        <= '0;
      out_addr_b        <= '0;
      out_twiddle       <= '0;
      out_stage         <= '0;
      out_last_in_stage <= 1'b0;
      out_last          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && start) begin
        if (legal) begin
          n_reg <= n_points;
          l_reg <= l_dec;
          s_cnt <= '0;
          b_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (load) begin
        out_valid         <= 1'b1;
        out_addr_a        <= addr_a;
        out_addr_b        <= addr_b;
        out_twiddle       <= rom_twiddle;
        out_stage         <= s_cnt;
        out_last_in_stage <= stage_end;
        out_last          <= frame_end;
        if (stage_end) begin
          b_cnt <= '0;
          s_cnt <= s_cnt + 1'b1;
        end else begin
          b_cnt <= b_cnt + 1'b1;
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (state == FLUSH && xfer) done <= 1'b1;
    end
  end

endmodule
